cg_fire_sequencer: RTL and testbench
====================================

# cg_fire_sequencer

Coil firing sequencer for the coilgun. It takes the 8-bit control register written over I2C by the `i2c_core` slave. On an armed fire request it energises the coil stages one at a time. Each stage hands off to the next when that stage's projectile gate sensor trips, or faults on a pulse timeout. A cooldown window follows every shot.

## Interface
- `STAGES`, 4: number of coil stages (2..8).
- `PULSE_MAX`, 50000: maximum on-time per coil, in `I_clk` cycles.
- `COOLDOWN`, 1000000: all-off hold after a completed or faulted shot, in cycles.
- `CW`, 24: internal counter width; must hold `max(PULSE_MAX, COOLDOWN)`.

Ports:
- `I_clk`  in  1: system clock, the same clock as `i2c_core`.
- `I_rst`  in  1: synchronous, active-high reset.
- `I_creg`  in  8: control register from `i2c_core` `O_creg`.
  - bit0 = ARM.
  - bit1 = FIRE, rising-edge triggered.
  - bits 7:2 are ignored.
- `I_sense`  in  STAGES: raw, asynchronous gate sensors, active high; bit k trips when the projectile passes stage k.
- `O_coil`  out  STAGES: coil drive, registered, one-hot or zero.
- `O_stage`  out  3: index of the active or last stage.
- `O_busy`  out  1: high in FIRE, GAP and COOL.
- `O_fault`  out  1: sticky timeout flag.
- `O_done`  out  1: one-cycle pulse when a full sequence completes.

## Operation
- `I_sense` passes through a 2-flop synchroniser, giving `sense_s`.
- FIRE edge detect: `fire_req = I_creg[1] & ~fire_q`, where `fire_q` is `I_creg[1]` registered.
- State machine states: IDLE, ARMED, FIRE, GAP, COOL, FAULT.
- **IDLE:** `O_coil = 0`. Go to ARMED when ARM = 1.
- **ARMED:**
  - ARM = 0 → IDLE.
  - `fire_req` → FIRE, with stage = 0 and the pulse counter cleared.
  - A FIRE edge seen in any other state is dropped, never queued.
- **FIRE:** `O_coil[stage] = 1`; the pulse counter increments every cycle.
  - `sense_s[stage]` high:
    - if stage = STAGES-1 → COOL, with `O_done` pulsed;
    - otherwise → GAP.
  - Counter reaches PULSE_MAX-1 with no sense → FAULT.
  - Sensors of non-active stages are ignored.
- **GAP:** exactly one cycle with all coils off (break-before-make). Then stage += 1, counter cleared, → FIRE.
- **FAULT:** `O_fault` is set and coils are off. Go to COOL in the next cycle.
- **COOL:**
  - Coils off; the cooldown counter runs for COOLDOWN cycles.
  - Then → ARMED if ARM = 1, otherwise → IDLE.
- **ARM dropped:** ARM = 0 in any state other than COOL forces IDLE on the next edge, with coils off on that same edge. This is an abort: `O_done` does not pulse, and `O_fault` is not set.
- **Fault clear:** `O_fault` clears only on reset or on an ARM 0→1 transition observed in IDLE.
- **O_stage:** holds the current stage in FIRE and GAP. In all other states it keeps the last stage fired. It is 0 after reset.
- **Simultaneous events in FIRE:**
  - Sense and timeout on the same cycle: sense wins, so the shot continues.
  - Sense and ARM drop on the same cycle: the abort wins.

## Timing
- **Reset values:**
  - `O_coil = 0`, `O_stage = 0`, `O_busy = 0`, `O_fault = 0`, `O_done = 0`.
  - State = IDLE; `fire_q`, the synchroniser flops and both counters are 0.
  - Reset during a shot turns the coils off on the reset edge.
- **Fire latency:** `I_creg[1]` rises before edge n; `O_coil[0]` is high after edge n+1.
- **Hand-off:**
  - Raw `I_sense[k]` rises before edge m, and `sense_s[k]` is high after edge m+1.
  - `O_coil[k]` falls after edge m+2.
  - If k < STAGES-1, `O_coil[k+1]` rises after edge m+3.
- **Timeout:** the coil stays high for exactly PULSE_MAX cycles. `O_fault` rises on the same edge the coil falls.
- **Cooldown:** `O_busy` stays high for COOLDOWN cycles after the final coil turns off; one further cycle may be spent in the FAULT state.
- **Done pulse:** `O_done` is asserted for one cycle, on the same edge the last coil falls.
- **Registration:** all outputs are registered, with no combinational path from inputs.

## Test plan
All scenarios use STAGES = 3, PULSE_MAX = 8, COOLDOWN = 16.
- **Full shot:** ARM = 1, FIRE edge, `I_sense[0..2]` pulsed 3 cycles after each respective coil rises.
  - `O_coil` sequence 001, 000, 010, 000, 100.
  - `O_done` pulses once; `O_busy` falls 16 cycles after the last coil falls; state returns to ARMED.
- **Timeout:** fire with no sense on stage 1.
  - `O_coil[1]` is high for exactly 8 cycles; `O_fault` = 1; `O_coil[2]` never rises.
  - After cooldown, ARM 1→0→1 clears `O_fault`.
- **Abort:** ARM drops while `O_coil[0]` is high.
  - Coils are 0 one edge later; state = IDLE; no `O_done`, no `O_fault`.
- **Rejected requests:**
  - FIRE edge with ARM = 0 → no coil activity.
  - FIRE held high → only one shot.
  - A second FIRE edge during COOL → ignored.
- **Sense edge cases:**
  - A wrong-stage sense (`I_sense[2]` during stage 0) → ignored.
  - Sense on the PULSE_MAX-1 cycle → the shot continues to stage 1.
- **Reset mid-shot:** `I_rst` asserted during stage 1 → all outputs 0 on that edge; a new fire after reset works normally.

Source files
------------

// File: rtl/cg_fire_sequencer.sv
// cg_fire_sequencer: coilgun stage sequencer. An armed FIRE edge energises
// the coils one at a time. Each stage hands off on its gate sensor or faults
// on a pulse timeout, and a cooldown window follows every shot.
module cg_fire_sequencer #(
    parameter int STAGES    = 4,
    parameter int PULSE_MAX = 50000,
    parameter int COOLDOWN  = 1000000,
    parameter int CW        = 24
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [7:0]        I_creg,
    input  logic [STAGES-1:0] I_sense,
    output logic [STAGES-1:0] O_coil,
    output logic [2:0]        O_stage,
    output logic              O_busy,
    output logic              O_fault,
    output logic              O_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_FIRE, S_GAP, S_COOL, S_FAULT
    } state_t;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_MAX - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN - 1);
    localparam logic [2:0]    STAGE_LAST = 3'(STAGES - 1);

    state_t            state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [CW-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic [CW-1:0]     cool_cnt_q, cool_cnt_d;
    logic [STAGES-1:0] sync_q, sense_s_q;
    logic [STAGES-1:0] coil_q, coil_d;
    logic              fire_q, fire_req_q, arm_q;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic              done_q, done_d;
    logic              arm, sense_hit;
    logic              unused_creg;

    assign arm         = I_creg[0];
    assign unused_creg = ^I_creg[7:2];
    // Only the active stage's synchronised sensor can end its pulse.
    assign sense_hit   = |(sense_s_q & (STAGES'(1) << stage_q));

    // Next-state logic; outputs are derived from the next state so every
    // output flop changes on the same edge as the state it reflects.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        pulse_cnt_d = pulse_cnt_q;
        cool_cnt_d  = cool_cnt_q;
        fault_d     = fault_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    if (!arm_q) fault_d = 1'b0;
                end
            end
            S_ARMED: begin
                if (fire_req_q) begin
                    state_d     = S_FIRE;
                    stage_d     = '0;
                    pulse_cnt_d = '0;
                end
            end
            S_FIRE: begin
                pulse_cnt_d = pulse_cnt_q + CW'(1);
                // Sense beats timeout when both land on the last pulse cycle.
                if (sense_hit) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d    = S_COOL;
                        cool_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end
            end
            S_GAP: begin
                state_d     = S_FIRE;
                stage_d     = stage_q + 3'd1;
                pulse_cnt_d = '0;
            end
            S_FAULT: begin
                state_d    = S_COOL;
                cool_cnt_d = '0;
            end
            S_COOL: begin
                cool_cnt_d = cool_cnt_q + CW'(1);
                if (cool_cnt_q == COOL_LAST) state_d = arm ? S_ARMED : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Disarm aborts everything except cooldown, with no done or fault.
        if (!arm && state_q != S_COOL) begin
            state_d = S_IDLE;
            stage_d = stage_q;
            done_d  = 1'b0;
            fault_d = fault_q;
        end
        coil_d = (state_d == S_FIRE) ? (STAGES'(1) << stage_d) : '0;
        // FAULT counts as busy so the flag does not dip between shot and cooldown.
        busy_d = (state_d == S_FIRE) || (state_d == S_GAP) ||
                 (state_d == S_COOL) || (state_d == S_FAULT);
    end

    // State, counters, synchronisers and registered outputs.
    // The FIRE edge is registered once more before the FSM acts on it,
    // which gives the two-edge fire latency.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            pulse_cnt_q <= '0;
            cool_cnt_q  <= '0;
            sync_q      <= '0;
            sense_s_q   <= '0;
            fire_q      <= 1'b0;
            fire_req_q  <= 1'b0;
            arm_q       <= 1'b0;
            coil_q      <= '0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            pulse_cnt_q <= pulse_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
            sync_q      <= I_sense;
            sense_s_q   <= sync_q;
            fire_q      <= I_creg[1];
            fire_req_q  <= I_creg[1] & ~fire_q;
            arm_q       <= arm;
            coil_q      <= coil_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            done_q      <= done_d;
        end
    end

    assign O_coil  = coil_q;
    assign O_stage = stage_q;
    assign O_busy  = busy_q;
    assign O_fault = fault_q;
    assign O_done  = done_q;

endmodule

// File: tb/tb_cg_fire_sequencer.sv
// Bench for cg_fire_sequencer: stimulus table, directed corner sequences and
// random traffic, all compared each cycle against a shot-level model.
module tb_cg_fire_sequencer;

    localparam int STAGES    = 3;
    localparam int PULSE_MAX = 8;
    localparam int COOLDOWN  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] creg = 8'h00;
    logic [2:0] sense = 3'b000;
    logic [2:0] O_coil, O_stage;
    logic       O_busy, O_fault, O_done;

    int checks = 0;
    int errors = 0;

    cg_fire_sequencer #(
        .STAGES(STAGES), .PULSE_MAX(PULSE_MAX), .COOLDOWN(COOLDOWN), .CW(24)
    ) dut (
        .I_clk(clk), .I_rst(rst), .I_creg(creg), .I_sense(sense),
        .O_coil(O_coil), .O_stage(O_stage), .O_busy(O_busy),
        .O_fault(O_fault), .O_done(O_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- shot-level reference model ----------------
    // Tracks "a shot is on", "in the dead gap", cycles the coil has been on,
    // cooldown cycles left and a one-cycle fault hold; sensors and the FIRE
    // input pass through two-deep history registers.
    logic m_shot, m_gap, m_ready, m_fault_hold, m_fault, m_done;
    int   m_stage, m_on, m_cool_left;
    logic m_f1, m_f2, m_arm_prev;
    logic [2:0] m_s1, m_s2;

    task automatic model_step();
        logic a, req;
        logic [2:0] ss;
        if (rst) begin
            m_shot = 0; m_gap = 0; m_ready = 0; m_fault_hold = 0; m_fault = 0;
            m_done = 0; m_stage = 0; m_on = 0; m_cool_left = 0;
            m_f1 = 0; m_f2 = 0; m_arm_prev = 0; m_s1 = 0; m_s2 = 0;
            return;
        end
        a = creg[0];
        req = m_f1 & ~m_f2;
        ss = m_s2;
        m_done = 0;
        if (m_cool_left > 0) begin
            m_cool_left--;
            if (m_cool_left == 0) m_ready = a;
        end else if (!a) begin
            m_shot = 0; m_gap = 0; m_fault_hold = 0; m_ready = 0;
        end else if (m_fault_hold) begin
            m_fault_hold = 0;
            m_cool_left = COOLDOWN;
        end else if (m_shot && m_gap) begin
            m_gap = 0; m_stage++; m_on = 1;
        end else if (m_shot) begin
            if (ss[m_stage]) begin
                if (m_stage == STAGES - 1) begin
                    m_shot = 0; m_cool_left = COOLDOWN; m_done = 1;
                end else m_gap = 1;
            end else if (m_on == PULSE_MAX) begin
                m_shot = 0; m_fault_hold = 1; m_fault = 1;
            end else m_on++;
        end else if (m_ready) begin
            if (req) begin m_shot = 1; m_gap = 0; m_stage = 0; m_on = 1; end
        end else begin
            m_ready = 1;
            if (!m_arm_prev) m_fault = 0;
        end
        m_f2 = m_f1; m_f1 = creg[1];
        m_s2 = m_s1; m_s1 = sense;
        m_arm_prev = a;
    endtask

    function automatic logic [8:0] model_out();
        logic [2:0] c;
        c = (m_shot && !m_gap) ? 3'(1 << m_stage) : 3'b000;
        return {c, 3'(m_stage), m_shot || m_cool_left > 0 || m_fault_hold, m_fault, m_done};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model", {O_coil, O_stage, O_busy, O_fault, O_done}, model_out());
    endtask

    task automatic wait_coil(input logic [2:0] want, input int bound, input string name);
        for (int i = 0; i < bound && O_coil !== want; i++) tick();
        chk(name, O_coil, want);
    endtask

    typedef struct {
        logic [7:0] creg;
        logic [2:0] sense;
        int         n;
        logic [2:0] coil;
        logic [2:0] stage;
        logic       busy;
        logic       fault;
        logic       done;
    } vec_t;

    function automatic vec_t v(input logic [7:0] c, input logic [2:0] s, input int n,
                               input logic [2:0] coil, input logic [2:0] st,
                               input logic b, input logic f, input logic d);
        vec_t r;
        r.creg = c; r.sense = s; r.n = n; r.coil = coil; r.stage = st;
        r.busy = b; r.fault = f; r.done = d;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        int cnt;
        logic seen2, fire_bit;

        // Full shot, held FIRE, abort, FIRE while disarmed.
        vecs.push_back(v(8'h01, 3'b000,  1, 3'b000, 3'd0, 0, 0, 0)); // arm
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b000, 3'd0, 0, 0, 0)); // FIRE rises
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b001, 3'd0, 1, 0, 0)); // coil0 on
        vecs.push_back(v(8'h03, 3'b000,  2, 3'b001, 3'd0, 1, 0, 0));
        vecs.push_back(v(8'h03, 3'b001,  1, 3'b001, 3'd0, 1, 0, 0)); // sense0
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b001, 3'd0, 1, 0, 0));
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b000, 3'd0, 1, 0, 0)); // gap
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b010, 3'd1, 1, 0, 0)); // coil1
        vecs.push_back(v(8'h03, 3'b000,  2, 3'b010, 3'd1, 1, 0, 0));
        vecs.push_back(v(8'h03, 3'b010,  1, 3'b010, 3'd1, 1, 0, 0)); // sense1
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b010, 3'd1, 1, 0, 0));
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b000, 3'd1, 1, 0, 0)); // gap
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b100, 3'd2, 1, 0, 0)); // coil2
        vecs.push_back(v(8'h03, 3'b000,  2, 3'b100, 3'd2, 1, 0, 0));
        vecs.push_back(v(8'h03, 3'b100,  1, 3'b100, 3'd2, 1, 0, 0)); // sense2
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b100, 3'd2, 1, 0, 0));
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b000, 3'd2, 1, 0, 1)); // done
        vecs.push_back(v(8'h03, 3'b000, 15, 3'b000, 3'd2, 1, 0, 0)); // cooldown
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b000, 3'd2, 0, 0, 0)); // busy falls
        vecs.push_back(v(8'h03, 3'b000,  2, 3'b000, 3'd2, 0, 0, 0)); // held FIRE
        vecs.push_back(v(8'h01, 3'b000,  1, 3'b000, 3'd2, 0, 0, 0));
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b000, 3'd2, 0, 0, 0));
        vecs.push_back(v(8'h03, 3'b000,  1, 3'b001, 3'd0, 1, 0, 0)); // still ARMED
        vecs.push_back(v(8'h02, 3'b000,  1, 3'b000, 3'd0, 0, 0, 0)); // abort
        vecs.push_back(v(8'h02, 3'b000,  3, 3'b000, 3'd0, 0, 0, 0));
        vecs.push_back(v(8'h00, 3'b000,  1, 3'b000, 3'd0, 0, 0, 0));
        vecs.push_back(v(8'h02, 3'b000,  4, 3'b000, 3'd0, 0, 0, 0)); // FIRE, disarmed

        // Reset state.
        tick(); tick();
        chk("reset_outputs", {O_coil, O_stage, O_busy, O_fault, O_done}, 9'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                creg = vecs[i].creg;
                sense = vecs[i].sense;
                tick();
                chk($sformatf("tbl%0d_coil", i), O_coil, vecs[i].coil);
                chk($sformatf("tbl%0d_stage", i), O_stage, vecs[i].stage);
                chk($sformatf("tbl%0d_busy", i), O_busy, vecs[i].busy);
                chk($sformatf("tbl%0d_fault", i), O_fault, vecs[i].fault);
                chk($sformatf("tbl%0d_done", i), O_done, vecs[i].done);
            end
        end

        // Wrong-stage sense, sense on the last pulse cycle, stage-1 timeout.
        creg = 8'h01; sense = 3'b000; tick();
        creg = 8'h03; tick(); tick();
        chk("seqA_fire", O_coil, 3'b001);
        tick();
        sense = 3'b100; tick();
        sense = 3'b000; tick(); tick(); tick();
        chk("wrong_stage_ignored", O_coil, 3'b001);
        sense = 3'b001; tick();
        sense = 3'b000; tick();
        chk("late_sense_still_on", O_coil, 3'b001);
        tick();
        chk("late_sense_gap", O_coil, 3'b000);
        chk("late_sense_no_fault", O_fault, 1'b0);
        tick();
        chk("late_sense_stage1", O_coil, 3'b010);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (O_coil[1]) cnt++; else break;
        end
        chk("timeout_len", cnt, PULSE_MAX);
        chk("timeout_fault", O_fault, 1'b1);
        chk("timeout_coil_off", O_coil, 3'b000);
        seen2 = 1'b0;
        for (int i = 0; i < 40 && O_busy; i++) begin
            tick();
            seen2 |= O_coil[2];
        end
        chk("timeout_cool_end", O_busy, 1'b0);
        chk("timeout_no_stage2", seen2, 1'b0);
        chk("fault_sticky", O_fault, 1'b1);
        creg = 8'h00; tick();
        chk("fault_sticky_disarm", O_fault, 1'b1);
        creg = 8'h01; tick();
        chk("fault_clear", O_fault, 1'b0);

        // Clean shot, then a FIRE edge during cooldown that must be dropped.
        creg = 8'h03; tick(); tick();
        chk("seqB_fire", O_coil, 3'b001);
        sense = 3'b001; tick(); sense = 3'b000;
        wait_coil(3'b010, 10, "seqB_stage1");
        sense = 3'b010; tick(); sense = 3'b000;
        wait_coil(3'b100, 10, "seqB_stage2");
        sense = 3'b100; tick(); sense = 3'b000;
        for (int i = 0; i < 10 && !O_done; i++) tick();
        chk("seqB_done", O_done, 1'b1);
        creg = 8'h01; tick(); tick();
        creg = 8'h03; tick(); tick();
        for (int i = 0; i < 30 && O_busy; i++) tick();
        chk("seqB_cool_end", O_busy, 1'b0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (O_coil != 3'b000) cnt++;
        end
        chk("cool_fire_dropped", cnt, 0);

        // Reset during stage 1, then a normal fire.
        creg = 8'h01; tick();
        creg = 8'h03; tick(); tick();
        sense = 3'b001; tick(); sense = 3'b000;
        wait_coil(3'b010, 10, "seqC_stage1");
        rst = 1'b1; tick();
        chk("reset_mid_shot", {O_coil, O_stage, O_busy, O_fault, O_done}, 9'd0);
        rst = 1'b0;
        creg = 8'h00; tick();
        creg = 8'h01; tick();
        creg = 8'h03; tick(); tick();
        chk("fire_after_reset", O_coil, 3'b001);
        creg = 8'h00; tick();

        // Random traffic against the model.
        fire_bit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            fire_bit ^= ($urandom_range(0, 5) == 0);
            creg = {6'($urandom), fire_bit, 1'($urandom_range(0, 49) != 0)};
            sense = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
